ireg_file: RTL and testbench

Integer register file serving the datapath's register interface: 64 × 32-bit registers, two combinational read ports (`ireg_r0`/`ireg_d0`, `ireg_r1`/`ireg_d1`) and one synchronous write port (`ireg_rw`/`ireg_dw`, gated by `ireg_we`). It sits between the datapath and the control unit. It also contains a debug dump engine that streams all registers out over a valid/ready handshake for the host-side monitor.

---
 rtl/osecpu_pkg.sv | 16 +
 rtl/ireg_dump_fsm.sv | 75 +++++++
 rtl/ireg_file.sv | 71 +++++++
 tb/tb_ireg_file.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osecpu_pkg.sv
// Shared types and constants for the integer register file and its dump engine.
package osecpu_pkg;

  localparam int unsigned IREG_AW = 6;
  localparam int unsigned IREG_DW = 32;

  typedef logic [IREG_AW-1:0] ireg_idx_t;
  typedef logic [IREG_DW-1:0] ireg_data_t;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_STREAM,
    DUMP_DONE
  } dump_state_e;

endpackage

// File: rtl/ireg_dump_fsm.sv
// Debug dump engine: walks register indices 0..DUMP_LAST and presents each one
// as a valid/ready beat. The array read for the current index is done by the
// parent through a dedicated read port (rd_idx -> rd_data).
module ireg_dump_fsm
  import osecpu_pkg::*;
#(
  parameter int unsigned DUMP_LAST = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dump_req,
  input  logic       dump_ready,
  input  ireg_data_t rd_data,
  output ireg_idx_t  rd_idx,
  output logic       dump_valid,
  output ireg_idx_t  dump_index,
  output ireg_data_t dump_data,
  output logic       dump_busy
);

  localparam ireg_idx_t LastIdx = ireg_idx_t'(DUMP_LAST);

  dump_state_e state_q, state_d;
  ireg_idx_t   idx_q, idx_d;

  // State and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state, index advance and handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (dump_req) begin
          state_d = DUMP_STREAM;
          idx_d   = '0;
        end
      end
      DUMP_STREAM: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = DUMP_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_DONE: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
  end

  assign rd_idx     = idx_q;
  assign dump_index = idx_q;
  // Data is forced to zero outside a beat so idle outputs stay quiet.
  assign dump_data  = dump_valid ? rd_data : '0;

endmodule

// File: rtl/ireg_file.sv
// Integer register file: two combinational read ports, one synchronous write
// port and a third read port feeding the debug dump engine.
// Optional feature: define IREG_BYPASS_EN to forward same-cycle write data to
// every read port (including the dump data path).
module ireg_file
  import osecpu_pkg::*;
#(
  parameter int unsigned NREG      = 64,
  parameter int unsigned DUMP_LAST = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  ireg_idx_t  ireg_r0,
  input  ireg_idx_t  ireg_r1,
  output ireg_data_t ireg_d0,
  output ireg_data_t ireg_d1,
  input  logic       ireg_we,
  input  ireg_idx_t  ireg_rw,
  input  ireg_data_t ireg_dw,
  input  logic       dump_req,
  output logic       dump_valid,
  input  logic       dump_ready,
  output ireg_idx_t  dump_index,
  output ireg_data_t dump_data,
  output logic       dump_busy
);

  ireg_data_t regs [NREG];
  ireg_idx_t  dump_rd_idx;
  ireg_data_t dump_rd_data;

  // Register array: cleared on reset, single write port otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (ireg_we) begin
      regs[ireg_rw] <= ireg_dw;
    end
  end

  // Read ports, optionally forwarding the in-flight write.
  always_comb begin
`ifdef IREG_BYPASS_EN
    ireg_d0      = (ireg_we && (ireg_r0 == ireg_rw)) ? ireg_dw : regs[ireg_r0];
    ireg_d1      = (ireg_we && (ireg_r1 == ireg_rw)) ? ireg_dw : regs[ireg_r1];
    dump_rd_data = (ireg_we && (dump_rd_idx == ireg_rw)) ? ireg_dw : regs[dump_rd_idx];
`else
    ireg_d0      = regs[ireg_r0];
    ireg_d1      = regs[ireg_r1];
    dump_rd_data = regs[dump_rd_idx];
`endif
  end

  ireg_dump_fsm #(
    .DUMP_LAST(DUMP_LAST)
  ) u_dump_fsm (
    .clk       (clk),
    .reset     (reset),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .rd_data   (dump_rd_data),
    .rd_idx    (dump_rd_idx),
    .dump_valid(dump_valid),
    .dump_index(dump_index),
    .dump_data (dump_data),
    .dump_busy (dump_busy)
  );

endmodule

// File: tb/tb_ireg_file.sv
// Self-checking bench for ireg_file: array model for reads, scoreboard queue of
// expected dump beats drained by an independent monitor.
module tb_ireg_file;
  import osecpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ireg_idx_t  ireg_r0, ireg_r1, ireg_rw;
  ireg_data_t ireg_d0, ireg_d1, ireg_dw;
  logic       ireg_we;
  logic       dump_req, dump_valid, dump_ready, dump_busy;
  ireg_idx_t  dump_index;
  ireg_data_t dump_data;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] model[64];
  int          total = 0;
  int          bad = 0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_idx = '0;

  always #5 clk = ~clk;

  ireg_file #(
    .NREG     (64),
    .DUMP_LAST(63)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireg_r0   (ireg_r0),
    .ireg_r1   (ireg_r1),
    .ireg_d0   (ireg_d0),
    .ireg_d1   (ireg_d1),
    .ireg_we   (ireg_we),
    .ireg_rw   (ireg_rw),
    .ireg_dw   (ireg_dw),
    .dump_req  (dump_req),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_index(dump_index),
    .dump_data (dump_data),
    .dump_busy (dump_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected value seen on a read port, given the write currently being driven.
  function automatic logic [31:0] exp_rd(input logic [5:0] idx);
    logic [31:0] v;
    v = model[idx];
`ifdef IREG_BYPASS_EN
    if (ireg_we && (idx == ireg_rw)) v = ireg_dw;
`endif
    return v;
  endfunction

  task automatic write(input logic [5:0] idx, input logic [31:0] data);
    ireg_we = 1'b1;
    ireg_rw = idx;
    ireg_dw = data;
    tick();
    model[idx] = data;
    ireg_we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [5:0] r0, input logic [5:0] r1);
    ireg_r0 = r0;
    ireg_r1 = r1;
    #1;
    check({name, "_d0"}, ireg_d0, exp_rd(r0));
    check({name, "_d1"}, ireg_d1, exp_rd(r1));
  endtask

  task automatic push_all();
    for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), model[i]});
  endtask

  // mode 0: ready high; 1: ready pattern 1-0-0-1; 2: random ready.
  task automatic run_dump(input int mode, input bit live_write);
    int   cyc;
    bit   did_live;
    logic [5:0]  k;
    logic [31:0] v;
    beat_t b;
    push_all();
    dump_req   = 1'b1;
    dump_ready = 1'b0;
    tick();
    dump_req = 1'b0;
    check("start_valid", 32'(dump_valid), 32'd1);
    check("start_index", 32'(dump_index), 32'd0);
    check("start_busy", 32'(dump_busy), 32'd1);
    cyc = 0;
    did_live = 1'b0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (live_write && !did_live && !dump_ready && dump_valid && cyc > 5) begin
        k = dump_index;
        v = $urandom;
        ireg_we = 1'b1;
        ireg_rw = k;
        ireg_dw = v;
        #1;
        check("dump_same_cycle", dump_data, exp_rd(k));
        tick();
        model[k] = v;
        ireg_we = 1'b0;
        b = exp_q.pop_front();
        b.data = v;
        exp_q.push_front(b);
        check("dump_after_write", dump_data, v);
        did_live = 1'b1;
      end else begin
        tick();
      end
      cyc++;
    end
    dump_ready = 1'b0;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: %0d beats missing", exp_q.size());
      exp_q.delete();
    end
    check("done_valid", 32'(dump_valid), 32'd0);
    check("done_busy", 32'(dump_busy), 32'd0);
    tick();
    check("idle_valid", 32'(dump_valid), 32'd0);
  endtask

  // Monitor: drains the scoreboard on every transfer and checks stall holding.
  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      if (prev_stall) begin
        check("stall_valid", 32'(dump_valid), 32'd1);
        check("stall_index", 32'(dump_index), 32'(prev_idx));
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: index %0d data %h with nothing expected", dump_index,
                   dump_data);
        end else begin
          b = exp_q.pop_front();
          check("beat_index", 32'(dump_index), 32'(b.idx));
          check("beat_data", dump_data, b.data);
        end
      end
    end
    prev_stall <= !reset && dump_valid && !dump_ready;
    prev_idx   <= dump_index;
  end

  initial begin
    int cyc;
    reset = 1'b1;
    ireg_r0 = '0;
    ireg_r1 = '0;
    ireg_we = 1'b0;
    ireg_rw = '0;
    ireg_dw = '0;
    dump_req = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_index", 32'(dump_index), 32'd0);
    check("rst_data", dump_data, 32'd0);
    read_check("rst_read", 6'd5, 6'd63);

    write(6'd5, 32'hFFFF_8000);
    read_check("wr5", 6'd5, 6'd0);
    ireg_we = 1'b0;
    ireg_rw = 6'd5;
    ireg_dw = '0;
    tick();
    read_check("we0_hold", 6'd5, 6'd5);

    // Same-cycle write and read of register 7.
    ireg_we = 1'b1;
    ireg_rw = 6'd7;
    ireg_dw = 32'h1234;
    read_check("bypass7", 6'd7, 6'd7);
    tick();
    model[7] = 32'h1234;
    ireg_we = 1'b0;
    read_check("after7", 6'd7, 6'd7);

    // Reset and dump_req together: reset wins.
    reset = 1'b1;
    dump_req = 1'b1;
    tick();
    reset = 1'b0;
    dump_req = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    check("rst_req_valid", 32'(dump_valid), 32'd0);
    read_check("rst_req_read", 6'd5, 6'd7);

    for (int i = 0; i < 64; i++) write(6'(i), 32'(i * 3));
    run_dump(0, 1'b0);
    run_dump(1, 1'b1);

    // Random concurrent reads/writes.
    for (int n = 0; n < 200; n++) begin
      ireg_we = 1'($urandom_range(0, 1));
      ireg_rw = 6'($urandom_range(0, 63));
      ireg_dw = $urandom;
      read_check("rand", 6'($urandom_range(0, 63)), ireg_rw);
      tick();
      if (ireg_we) model[ireg_rw] = ireg_dw;
      ireg_we = 1'b0;
    end
    run_dump(2, 1'b1);

    // Reset in the middle of a dump, at beat 20.
    push_all();
    dump_req = 1'b1;
    dump_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0;
    while (exp_q.size() > 44 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("beats_before_reset", 32'(exp_q.size()), 32'd44);
    reset = 1'b1;
    dump_ready = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) model[i] = '0;
    check("midrst_valid", 32'(dump_valid), 32'd0);
    check("midrst_busy", 32'(dump_busy), 32'd0);
    for (int i = 0; i < 64; i++) read_check("midrst_read", 6'(i), 6'(63 - i));
    run_dump(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
